// File: rtl/usb_gpif_pkg.sv
// Shared GPIF-II definitions: write-FSM state encoding, source mode codes
// and the word-counter width helper.
package usb_gpif_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_WRITE    = 3'd3,
        ST_TURN     = 3'd4
    } gpif_state_t;

    localparam logic MODE_PATTERN = 1'b0;
    localparam logic MODE_STREAM  = 1'b1;

    // Counter wide enough to hold indices 0..len-1, never narrower than 1 bit.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/usb_stream_in_ctrl.sv
// Streams bursts of words into an FX3 socket over the GPIF-II slave FIFO
// write interface. Data comes either from a counter test pattern or from a
// valid/ready source stream; short packets are committed with pktend.
module usb_stream_in_ctrl
    import usb_gpif_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4096,
    parameter int NUM_CH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pclk_in,
    input  logic              enable,
    input  logic              mode,
    input  logic [1:0]        ch_sel,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              flag_a,
    input  logic              flag_b,
    output logic              pclk,
    output logic              slcs,
    output logic              sloe,
    output logic              slrd,
    output logic              slwr,
    output logic              pktend,
    output logic [1:0]        fifo_addr,
    output logic [DATA_W-1:0] usb_data,
    output logic              usb_data_oe,
    output logic              burst_done
);

    localparam int              CW       = cnt_width(BURST_LEN);
    localparam int              PW       = (CW < DATA_W) ? CW : DATA_W;
    localparam logic [CW-1:0]   LAST_IDX = CW'(BURST_LEN - 1);

    gpif_state_t       state, state_nx;
    logic [CW-1:0]     cnt;
    logic              mode_q;
    logic              start;
    logic              take;
    logic              done_full;
    logic              done_short;
    logic [1:0]        ch_wrap;
    logic [DATA_W-1:0] pat;

    // Write-only slave FIFO: chip select, output enable and read strobe fixed.
    assign pclk        = pclk_in;
    assign slcs        = 1'b0;
    assign sloe        = 1'b1;
    assign slrd        = 1'b1;
    assign usb_data_oe = ~slwr;

    // Socket number folded into the implemented range; pattern word is the
    // in-burst index, zero-extended or truncated to the bus width.
    always_comb begin
        ch_wrap         = 2'({30'd0, ch_sel} % NUM_CH);
        pat             = '0;
        pat[PW-1:0]     = cnt[PW-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic. flag_a only gates entry to WRITE; flag_b loss pauses
    // the burst in WAIT_RDY with the word index preserved.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (start)            state_nx = ST_ADDR;
            ST_ADDR:                           state_nx = ST_WAIT_RDY;
            ST_WAIT_RDY: if (flag_a && flag_b) state_nx = ST_WRITE;
            ST_WRITE: begin
                if (!flag_b)                       state_nx = ST_WAIT_RDY;
                else if (done_full || done_short)  state_nx = ST_TURN;
            end
            ST_TURN:                           state_nx = ST_IDLE;
            default:                           state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: burst start, word take, handshake and completion decode.
    always_comb begin
        start      = (state == ST_IDLE) && enable && ((mode == MODE_PATTERN) || s_valid);
        s_ready    = 1'b0;
        take       = 1'b0;
        if (state == ST_WRITE) begin
            s_ready = (mode_q == MODE_STREAM) && flag_b;
            take    = flag_b && ((mode_q == MODE_PATTERN) || s_valid);
        end
        done_full  = take && (cnt == LAST_IDX);
        done_short = take && (mode_q == MODE_STREAM) && s_last && !done_full;
    end

    // Burst context: mode and socket latch at start, index runs until TURN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_PATTERN;
            fifo_addr <= '0;
            cnt       <= '0;
        end else begin
            if (start) begin
                mode_q    <= mode;
                fifo_addr <= ch_wrap;
            end
            if (state == ST_TURN) cnt <= '0;
            else if (take)        cnt <= cnt + 1'b1;
        end
    end

    // Registered bus stage: each taken word appears one cycle later with
    // slwr low; a short-packet commit rides on the same cycle as its word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slwr       <= 1'b1;
            pktend     <= 1'b1;
            usb_data   <= '0;
            burst_done <= 1'b0;
        end else begin
            slwr       <= ~take;
            pktend     <= ~done_short;
            burst_done <= (state == ST_TURN);
            if (take) usb_data <= (mode_q == MODE_STREAM) ? s_data : pat;
        end
    end

endmodule

// File: tb/tb_usb_stream_in_ctrl.sv
// Scoreboard bench for usb_stream_in_ctrl with BURST_LEN=8: stimulus pushes
// expected bus words, a negedge monitor pops and compares on every slwr=0.
module tb_usb_stream_in_ctrl;

    localparam int DW = 32;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pclk_in = 1'b0;
    logic          enable = 1'b0;
    logic          mode = 1'b0;
    logic [1:0]    ch_sel = 2'd0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          flag_a = 1'b1;
    logic          flag_b = 1'b1;
    logic          pclk, slcs, sloe, slrd, slwr, pktend, usb_data_oe, burst_done;
    logic [1:0]    fifo_addr;
    logic [DW-1:0] usb_data;

    usb_stream_in_ctrl #(.DATA_W(DW), .BURST_LEN(BL), .NUM_CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pclk_in(pclk_in), .enable(enable), .mode(mode),
        .ch_sel(ch_sel), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .flag_a(flag_a), .flag_b(flag_b), .pclk(pclk),
        .slcs(slcs), .sloe(sloe), .slrd(slrd), .slwr(slwr), .pktend(pktend),
        .fifo_addr(fifo_addr), .usb_data(usb_data), .usb_data_oe(usb_data_oe),
        .burst_done(burst_done)
    );

    always #5 clk = ~clk;
    always #7 pclk_in = ~pclk_in;

    typedef struct { logic [DW-1:0] d; logic pk; logic last; } exp_t;
    typedef struct { logic [DW-1:0] d; logic last; logic vld; } src_t;

    exp_t exp_q[$];
    src_t src_q[$];
    int   checks = 0;
    int   errors = 0;
    int   words_seen = 0;
    logic done_pend = 1'b0;
    exp_t e;
    logic exp_done;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic pk, input logic last);
        exp_t x;
        x.d = d; x.pk = pk; x.last = last;
        exp_q.push_back(x);
    endtask

    task automatic push_src(input logic [DW-1:0] d, input logic last, input logic vld);
        src_t x;
        x.d = d; x.last = last; x.vld = vld;
        src_q.push_back(x);
    endtask

    function automatic void present();
        s_valid = (src_q.size() > 0) && src_q[0].vld;
        s_data  = (src_q.size() > 0) ? src_q[0].d : '0;
        s_last  = (src_q.size() > 0) && src_q[0].last;
    endfunction

    // Stream source: gap entries last one cycle, data entries until accepted.
    always @(posedge clk) begin
        if (src_q.size() > 0 && (!src_q[0].vld || s_ready)) void'(src_q.pop_front());
        #1 present();
    end

    // Monitor: compare every bus write against the scoreboard and check the
    // done pulse lands exactly one cycle after a burst's final word.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_done  = done_pend;
            done_pend = 1'b0;
            if (!flag_b) chk("s_ready_when_flag_b_low", {31'd0, s_ready}, 0);
            if (slwr === 1'b0) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got data %0h, expected no write", usb_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("usb_data", usb_data, e.d);
                    chk("pktend", {31'd0, pktend}, {31'd0, e.pk});
                    done_pend = e.last;
                end
            end else begin
                chk("pktend_idle", {31'd0, pktend}, 1);
            end
            chk("burst_done", {31'd0, burst_done}, {31'd0, exp_done});
            chk("usb_data_oe", {31'd0, usb_data_oe}, {31'd0, ~slwr});
        end
    end

    task automatic pulse_enable(input logic m, input logic [1:0] ch);
        @(posedge clk); #1;
        mode = m; ch_sel = ch; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; ch_sel = 2'd0;
    endtask

    task automatic wait_words(input int n);
        int k;
        for (k = 0; k < 200 && words_seen < n; k++) begin
            @(negedge clk); #1;
        end
        if (words_seen < n) begin
            checks++; errors++;
            $display("FAIL wait_words_timeout: got %0d words, expected %0d", words_seen, n);
        end
    endtask

    task automatic wait_done(input string nm);
        int   k;
        logic seen;
        seen = 1'b0;
        for (k = 0; k < 200 && !seen; k++) begin
            @(negedge clk); #1;
            seen = burst_done;
        end
        chk({nm, "_done_seen"}, {31'd0, seen}, 1);
        chk({nm, "_scoreboard_empty"}, exp_q.size(), 0);
        words_seen = 0;
    endtask

    initial begin
        // Reset values while rst_n is held low.
        #12;
        chk("rst_slwr", {31'd0, slwr}, 1);
        chk("rst_pktend", {31'd0, pktend}, 1);
        chk("rst_fifo_addr", {30'd0, fifo_addr}, 0);
        chk("rst_usb_data", usb_data, 0);
        chk("rst_burst_done", {31'd0, burst_done}, 0);
        chk("rst_s_ready", {31'd0, s_ready}, 0);
        chk("rst_oe", {31'd0, usb_data_oe}, 0);
        chk("slcs_sloe_slrd", {29'd0, slcs, sloe, slrd}, 32'b011);
        chk("pclk_fwd", {31'd0, pclk}, {31'd0, pclk_in});
        @(negedge clk); #1 rst_n = 1'b1;

        // Pattern burst, 8 words 0..7, no pktend.
        for (int i = 0; i < BL; i++) push_exp(i, 1'b1, i == BL - 1);
        pulse_enable(1'b0, 2'd0);
        chk("pat_fifo_addr", {30'd0, fifo_addr}, 0);
        wait_done("pattern8");

        // Stream short packet A,B,C with s_last on C.
        push_src(32'hA, 1'b0, 1'b1); push_src(32'hB, 1'b0, 1'b1); push_src(32'hC, 1'b1, 1'b1);
        present();
        push_exp(32'hA, 1'b1, 1'b0); push_exp(32'hB, 1'b1, 1'b0); push_exp(32'hC, 1'b0, 1'b1);
        pulse_enable(1'b1, 2'd1);
        chk("short_fifo_addr", {30'd0, fifo_addr}, 1);
        wait_done("short3");

        // flag_b drop after word 4 for 5 cycles; data resumes at 4.
        for (int i = 0; i < BL; i++) push_exp(i, 1'b1, i == BL - 1);
        pulse_enable(1'b0, 2'd0);
        wait_words(4);
        flag_b = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            chk("gap_slwr", {31'd0, slwr}, 1);
        end
        flag_b = 1'b1;
        wait_done("flagb_gap");

        // Socket 2 with flag_a low: address held, no writes until ready.
        flag_a = 1'b0;
        for (int i = 0; i < BL; i++) push_exp(i, 1'b1, i == BL - 1);
        pulse_enable(1'b0, 2'd2);
        repeat (10) begin
            @(negedge clk); #1;
            chk("flaga_fifo_addr", {30'd0, fifo_addr}, 2);
            chk("flaga_slwr", {31'd0, slwr}, 1);
        end
        flag_a = 1'b1;
        wait_done("flaga_wait");

        // Reset mid-burst after three words; outputs clear asynchronously.
        for (int i = 0; i < BL; i++) push_exp(i, 1'b1, i == BL - 1);
        pulse_enable(1'b0, 2'd1);
        wait_words(3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_slwr", {31'd0, slwr}, 1);
        chk("arst_pktend", {31'd0, pktend}, 1);
        chk("arst_fifo_addr", {30'd0, fifo_addr}, 0);
        chk("arst_usb_data", usb_data, 0);
        chk("arst_burst_done", {31'd0, burst_done}, 0);
        exp_q.delete();
        done_pend  = 1'b0;
        words_seen = 0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < BL; i++) push_exp(i, 1'b1, i == BL - 1);
        pulse_enable(1'b0, 2'd3);
        chk("post_rst_fifo_addr", {30'd0, fifo_addr}, 3);
        wait_done("after_reset");

        // Stream with valid gaps and a flag_b pause; short commit on last.
        push_src(32'h11, 1'b0, 1'b1); push_src(0, 1'b0, 1'b0);
        push_src(32'h22, 1'b0, 1'b1); push_src(0, 1'b0, 1'b0); push_src(0, 1'b0, 1'b0);
        push_src(32'h33, 1'b0, 1'b1); push_src(32'h44, 1'b1, 1'b1);
        present();
        push_exp(32'h11, 1'b1, 1'b0); push_exp(32'h22, 1'b1, 1'b0);
        push_exp(32'h33, 1'b1, 1'b0); push_exp(32'h44, 1'b0, 1'b1);
        pulse_enable(1'b1, 2'd0);
        wait_words(1);
        flag_b = 1'b0;
        #1 chk("s_ready_drop_in_write", {31'd0, s_ready}, 0);
        repeat (3) @(negedge clk);
        #1 flag_b = 1'b1;
        wait_done("stream_gaps");

        // Stream full burst with s_last on index 7: no pktend.
        for (int i = 0; i < BL; i++) begin
            push_src(32'h100 + i, i == BL - 1, 1'b1);
            push_exp(32'h100 + i, 1'b1, i == BL - 1);
        end
        present();
        pulse_enable(1'b1, 2'd0);
        wait_done("stream_full_last");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
